// File: rtl/mac_dot_feeder.sv
// Operand-side controller for the FP MAC: streams len operand pairs,
// clears the accumulator first, waits out MAC latency, returns MacOut.
module mac_dot_feeder #(
  parameter int MAC_LAT = 1,
  parameter int LEN_W   = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic [31:0]      mac_in1,
  output logic [31:0]      mac_in2,
  output logic             mac_clr,
  input  logic [31:0]      mac_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data
);

  localparam int DW = $clog2(MAC_LAT + 2);
  localparam logic [DW-1:0] LAT = DW'(MAC_LAT);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    HOLD
  } state_e;

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [DW-1:0]    drn_q;
  logic [31:0]      in1_q;
  logic [31:0]      in2_q;
  logic             rv_q;
  logic [31:0]      rd_q;

  assign busy      = (state_q != IDLE);
  assign op_ready  = (state_q == FEED);
  assign mac_clr   = (state_q == CLEAR);
  assign mac_in1   = in1_q;
  assign mac_in2   = in2_q;
  assign res_valid = rv_q;
  assign res_data  = rd_q;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      drn_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      // Idle cycles feed +0*+0 so the running sum is untouched.
      in1_q <= '0;
      in2_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              len_q   <= len;
              cnt_q   <= '0;
              state_q <= CLEAR;
            end else begin
              rd_q    <= '0;
              rv_q    <= 1'b1;
              state_q <= HOLD;
            end
          end
        end
        CLEAR: state_q <= FEED;
        FEED: begin
          if (op_valid) begin
            in1_q <= op_a;
            in2_q <= op_b;
            cnt_q <= cnt_q + LEN_W'(1);
            if (cnt_q == len_q - LEN_W'(1)) begin
              drn_q   <= LAT;
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drn_q == '0) begin
            rd_q    <= mac_out;
            rv_q    <= 1'b1;
            state_q <= HOLD;
          end else begin
            drn_q <= drn_q - DW'(1);
          end
        end
        HOLD: begin
          if (res_ready) begin
            rv_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_feeder.sv
// Directed bench for mac_dot_feeder with a behavioural MAC and
// a pair/sum scoreboard checked every cycle.
module tb_mac_dot_feeder;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        busy;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] mac_in1;
  logic [31:0] mac_in2;
  logic        mac_clr;
  logic [31:0] mac_out;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  bit chk_en = 0;

  mac_dot_feeder #(.MAC_LAT(1), .LEN_W(8)) dut (
    .CLK(CLK), .rst(rst), .start(start), .len(len), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_in1(mac_in1), .mac_in2(mac_in2), .mac_clr(mac_clr),
    .mac_out(mac_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  function automatic real s2r(input logic [31:0] b);
    logic [63:0] d;
    int e;
    if (b[30:0] == 31'd0) return 0.0;
    e = int'(b[30:23]) - 127 + 1023;
    d = {b[31], 11'(e), b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], 8'(e), d[51:29]};
  endfunction

  // Behavioural MAC: one-cycle accumulate, clear wins
  real acc;
  always @(posedge CLK or posedge rst) begin
    if (rst) acc <= 0.0;
    else if (mac_clr) acc <= 0.0;
    else acc <= acc + s2r(mac_in1) * s2r(mac_in2);
  end
  assign mac_out = r2s(acc);

  // Scoreboard: accepted pairs, their dot product, expected MAC drive
  real         m_sum;
  int          m_cnt;
  int          m_len;
  logic [31:0] e_in1;
  logic [31:0] e_in2;
  logic        e_clr;
  always @(posedge CLK or posedge rst) begin
    if (rst) begin
      m_sum = 0.0; m_cnt = 0; m_len = 0;
      e_in1 = '0; e_in2 = '0; e_clr = 1'b0;
    end else begin
      e_in1 = '0;
      e_in2 = '0;
      e_clr = start && !busy && (len != 8'd0);
      if (start && !busy) begin
        m_sum = 0.0; m_cnt = 0; m_len = int'(len);
      end
      if (op_valid && op_ready) begin
        m_sum = m_sum + s2r(op_a) * s2r(op_b);
        m_cnt++;
        e_in1 = op_a;
        e_in2 = op_b;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (!rst && chk_en) begin
      chk("mac_in1", mac_in1, e_in1);
      chk("mac_in2", mac_in2, e_in2);
      chk("mac_clr", 32'(mac_clr), 32'(e_clr));
      if (op_ready) chk("overfeed", 32'(m_cnt < m_len), 32'd1);
      if (res_valid) begin
        chk("sb_res", res_data, r2s(m_sum));
        chk("sb_accepts", 32'(m_cnt), 32'(m_len));
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_opr"}, 32'(op_ready), 32'd0);
    chk({nm, "_in1"}, mac_in1, 32'd0);
    chk({nm, "_in2"}, mac_in2, 32'd0);
    chk({nm, "_clr"}, 32'(mac_clr), 32'd0);
    chk({nm, "_rv"}, 32'(res_valid), 32'd0);
    chk({nm, "_rd"}, res_data, 32'd0);
  endtask

  task automatic do_start(input logic [7:0] n, output int s);
    start = 1'b1;
    len = n;
    @(posedge CLK);
    #1;
    s = cyc;
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input int gap);
    bit ok = 0;
    op_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge CLK);
      #1;
    end
    op_valid = 1'b1;
    op_a = a;
    op_b = b;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (op_ready) begin
        @(posedge CLK);
        #1;
        ok = 1;
        break;
      end
    end
    op_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic get_res(input string nm, input logic [31:0] exp,
                         input int ecyc, input int hold);
    bit ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (res_valid) begin
        ok = 1;
        break;
      end
    end
    chk({nm, "_seen"}, 32'(ok), 32'd1);
    chk({nm, "_data"}, res_data, exp);
    chk({nm, "_lat"}, 32'(cyc), 32'(ecyc));
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK);
      #1;
      start = (h == 1);
      len = 8'd1;
      @(negedge CLK);
      chk({nm, "_hold_rv"}, 32'(res_valid), 32'd1);
      chk({nm, "_hold_rd"}, res_data, exp);
      chk({nm, "_hold_opr"}, 32'(op_ready), 32'd0);
      chk({nm, "_hold_busy"}, 32'(busy), 32'd1);
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(posedge CLK);
    #1;
    res_ready = 1'b0;
    chk({nm, "_idle_rv"}, 32'(res_valid), 32'd0);
    chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s;
    repeat (2) @(posedge CLK);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    chk_en = 1;

    // 1.5*2.5 + 0.5*-4 = 1.75
    do_start(8'd2, s);
    send(32'h3FC00000, 32'h40200000, 0);
    send(32'h3F000000, 32'hC0800000, 0);
    get_res("t1", 32'h3FE00000, s + 5, 0);

    // back-to-back: 7*3 = 21, no carry-over
    do_start(8'd1, s);
    send(32'h40E00000, 32'h40400000, 0);
    get_res("t2", 32'h41A80000, s + 4, 0);

    // 3-cycle op_valid gap between pairs
    do_start(8'd2, s);
    send(32'h3FC00000, 32'h40200000, 0);
    send(32'h3F000000, 32'hC0800000, 3);
    get_res("t3", 32'h3FE00000, s + 8, 0);

    // consumer stall with a start pulse inside HOLD
    do_start(8'd1, s);
    send(32'h40E00000, 32'h40400000, 0);
    get_res("t4", 32'h41A80000, s + 4, 5);

    // zero-length command
    do_start(8'd0, s);
    chk("t5_opr", 32'(op_ready), 32'd0);
    chk("t5_clr", 32'(mac_clr), 32'd0);
    get_res("t5", 32'h0, s, 0);

    // asynchronous reset mid-FEED
    do_start(8'd2, s);
    send(32'h3FC00000, 32'h40200000, 0);
    #3;
    rst = 1'b1;
    #1;
    chk_zero("t6_rst");
    @(posedge CLK);
    #1;
    chk_zero("t6_held");
    rst = 1'b0;
    do_start(8'd1, s);
    send(32'h40E00000, 32'h40400000, 0);
    get_res("t6", 32'h41A80000, s + 4, 0);

    repeat (3) @(posedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mac_dot_feeder.md
Name: mac_dot_feeder

Overview:
- Operand-side controller for the floating-point `mac` unit.
- Accepts a start command with a term count, then streams IEEE-754 single-precision operand pairs into the MAC's In1/In2 through a valid/ready handshake.
- Clears the accumulator before each dot product, waits out the MAC latency, and returns the final MacOut as a result with a valid/ready handshake.
- Sits between the operand source (memory reader or host FIFO) and `mac`.

Parameters:
- MAC_LAT, 1: cycles from a value on In1/In2 being sampled by the MAC to MacOut reflecting it.
- LEN_W, 8: width of the term-count input.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command pulse; accepted only in IDLE.
- len  in  LEN_W  number of operand pairs; latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- op_valid  in  1  operand pair available.
- op_ready  out  1  feeder accepts a pair this cycle.
- op_a  in  32  operand A (IEEE-754).
- op_b  in  32  operand B (IEEE-754).
- mac_in1  out  32  drives MAC In1; registered.
- mac_in2  out  32  drives MAC In2; registered.
- mac_clr  out  1  accumulator clear request, active-high; the integration wrapper maps it onto the MAC reset.
- mac_out  in  32  MAC MacOut.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  32  captured dot-product result.

Behaviour:
- Reset (async, immediate): state=IDLE.
  - Outputs: busy=0, op_ready=0, mac_in1=mac_in2=0, mac_clr=0, res_valid=0, res_data=0.
  - Counters cleared.
  - Reset mid-operation abandons the transaction; nothing is produced for it.
- Zero drive: the MAC accumulates every clock. mac_in1/mac_in2 register 32'h0 on every edge without an accepted operand pair, so +0*+0 is added and the sum is unchanged.
- IDLE:
  - op_ready=0.
  - start=1 with len!=0: latch len, clear term counter, go to CLEAR.
  - start=1 with len==0: res_data<=0, res_valid<=1, go to HOLD; mac_clr is not asserted.
- CLEAR:
  - mac_clr=1 for exactly this one cycle.
  - Go to FEED.
- FEED:
  - op_ready=1 (combinational from state).
  - On an edge with op_valid&op_ready: mac_in1<=op_a, mac_in2<=op_b, count++.
  - op_valid may drop at any time; gap cycles feed zeros.
  - When the accepted pair is number len: op_ready deasserts from the next cycle and the state goes to DRAIN with drain counter = MAC_LAT.
  - Never accepts more than len pairs.
- DRAIN:
  - op_ready=0, zeros fed.
  - If the last pair is accepted at edge E, mac_out reflects it after edge E+MAC_LAT.
  - res_data<=mac_out and res_valid<=1 at edge E+MAC_LAT+1; go to HOLD.
- HOLD:
  - res_valid=1; res_data stable until res_valid&res_ready.
  - On handshake: res_valid<=0, go to IDLE.
  - start is ignored.
- start in any non-IDLE state is ignored; the command is not queued.
- Latency for len=N with continuous op_valid:
  - Start accepted at edge S.
  - mac_clr high in cycle S..S+1.
  - First acceptance at edge S+2; last acceptance at S+N+1.
  - res_valid rises after edge S+N+MAC_LAT+2.
- Back-to-back: start is accepted in the cycle after the result handshake returns the block to IDLE.
- No FP arithmetic is performed in this block; values pass through bit-exact.

Test Plan:
- len=2, pairs (3FC00000,40200000), (C0000000?) → use (3FC00000,40200000),(3F000000,C0800000), continuous valid, MAC_LAT=1 → res_data=3FE00000 (1.75); res_valid after edge S+5.
- Follow-up len=1, pair (40E00000,40400000) → res_data=41A80000 (21.0); proves mac_clr pulse and no carry-over from the previous sum.
- Test 1 stimulus with op_valid low for 3 cycles between the pairs → same 3FE00000; mac_in1/mac_in2=0 during the gap; exactly 2 acceptances.
- res_ready held low for 5 cycles in HOLD, with start pulsed during that time → res_valid and res_data stable, op_ready=0, start ignored; released at handshake, IDLE next cycle.
- len=0 start → res_valid=1 one cycle later with res_data=0; no mac_clr pulse; no op_ready.
- rst asserted mid-FEED between clock edges → all outputs 0 immediately; a new len=1 (40E00000,40400000) afterwards gives 41A80000.
